rsa_modmul_sched: RTL and testbench
===================================

# rsa_modmul_sched

Round-robin scheduler that shares one sequential 128-bit multiplier and one sequential 128-bit divider among several requesters. Each requester needs one modular multiply, (a·b) mod n, such as the encryptor and decryptor exponentiation loops. For each granted request the block sequences multiply, then divide, and returns the divider remainder. It sits between the exponentiation FSMs and the `SequentialMultiplier128Bit` / `rsa_div` instances, which are instantiated outside it.

## Interface
- `WIDTH`, 128, operand width
- `NREQ`, 2, number of requesters (2..8)
- `clk  in  1  clock`
- `reset  in  1  reset reset, synchronous, active-high; clock clk`
- `req  in  NREQ  request, one bit per requester, level`
- `op_a / op_b / op_n  in  NREQ*WIDTH each  per-requester operands, requester i at slice [i*WIDTH +: WIDTH]`
- `gnt  out  NREQ  one-hot owner of the engines, registered`
- `rsp_valid  out  NREQ  one-cycle pulse to the owner when the result is ready`
- `rsp_data  out  WIDTH  result; valid only while `rsp_valid` is nonzero`
- `rsp_err  out  1  qualifies `rsp_valid`; high when op_n == 0`
- `mult_rst_n  out  1  multiplier start/reset, active-low`
- `mult_a / mult_b  out  WIDTH  multiplier operands`
- `mult_done  in  1  multiplier done`
- `prod  in  2*WIDTH  multiplier product`
- `div_rst_n  out  1  divider start/reset, active-low`
- `div_a  out  2*WIDTH  dividend`
- `div_b  out  WIDTH  divisor`
- `div_done  in  1  divider done`
- `rem_in  in  WIDTH  divider remainder`

## Operation
- **Reset values:** `gnt`=0, `rsp_valid`=0, `rsp_data`=0, `rsp_err`=0, `mult_rst_n`=0, `div_rst_n`=0, operand outputs=0, round-robin pointer=0, state IDLE.
- **Engine reset:** both engines are held in reset for the duration of `reset`. Outside reset, `*_rst_n` rests at 1.
- **States:** IDLE, MUL_GO, MUL_WAIT, DIV_GO, DIV_WAIT, RESP.
- **IDLE:**
  - Pick the first asserted `req` at or after the pointer, wrapping.
  - Set `gnt`.
  - Latch that requester's a, b and n into internal registers.
  - Go to MUL_GO.
  - If the latched n == 0, go straight to RESP with `rsp_err`=1 and `rsp_data`=0.
- **MUL_GO:** drive `mult_a`/`mult_b` from the latches, hold `mult_rst_n`=0 for exactly one cycle, then go to MUL_WAIT.
- **MUL_WAIT:** `mult_rst_n`=1. When `mult_done`=1, capture `prod` into a 2*WIDTH register and go to DIV_GO.
- **DIV_GO:** `div_a` = captured product, `div_b` = latched n, `div_rst_n`=0 for one cycle, then go to DIV_WAIT.
- **DIV_WAIT:** when `div_done`=1, capture `rem_in` into `rsp_data` and go to RESP.
- **RESP:**
  - Pulse `rsp_valid` on the owner's bit for one cycle.
  - Clear `gnt`.
  - Move the pointer to owner+1 mod NREQ.
  - Return to IDLE.
- **Requester rule:** operands only need to be stable in the IDLE cycle where the requester is granted. A `req` still high in the IDLE cycle after `rsp_valid` starts a new operation.
- **Request withdrawal:** dropping `req` mid-operation does not abort it; the result is still delivered.
- **Done sampling:** a `*_done` level is only sampled in the WAIT states. Stale done from a previous op is cleared by the GO-cycle reset pulse.
- **Reset mid-operation:** abandon the op immediately with no `rsp_valid`, apply all reset values, and put the pointer back to 0.

## Timing
- **Arbitration:** `req` is sampled at clock edge E0 (IDLE); `gnt` is visible after E0.
- **Latency:** `rsp_valid` is high during cycle E0 + 4 + Tm + Td.
  - Tm = MUL_WAIT cycles until `mult_done`; Td = DIV_WAIT cycles until `div_done`.
  - Both are nominally 128 or more.
- **Error path:** with n==0, `rsp_valid` is high during cycle E0+1.
- **Back-to-back:** the next grant can happen one cycle after RESP. There is no overlap; the engines are never shared concurrently.
- **Zero-cycle done:** `done` already high on the first WAIT cycle is accepted.

## Configuration
- `RSA_MODMUL_SKIP_DIV_EN`
- **Defined:** in MUL_WAIT, if `prod[2*WIDTH-1:WIDTH]`==0 and `prod[WIDTH-1:0]` < n, then `rsp_data` = `prod[WIDTH-1:0]`. The block goes directly to RESP with Td = 0 and DIV_GO skipped, and `div_rst_n` never pulses.
- **Undefined:** the divider is always used.

## Structure
- **Shared package `rsa_pkg`:**
  - `RSA_WIDTH`=128
  - state enum `modmul_state_t`
  - `NREQ` default
- **Sub-module `rr_arbiter`:** parameterised NREQ; inputs `req` and pointer; outputs one-hot winner and `any`.

## Test plan
- **Single op:** req0, a=7, b=9, n=10 → `rsp_valid`=2'b01, `rsp_data`=3, `rsp_err`=0. Latency matches E0 + 4 + Tm + Td.
- **Simultaneous requests:** `req`=2'b11 held after reset → grants alternate 0, 1, 0, 1.
  - r0: a=5, b=5, n=7 → 4.
  - r1: a=2^127, b=2, n=2^127−1 → 2.
- **Divide by zero:** n=0 on req1 → `rsp_valid`=2'b10 during cycle E0+1, `rsp_err`=1, `rsp_data`=0, `mult_rst_n` never pulses.
- **Large operands:** a = b = n−1 with n=2^128−159 → `rsp_data`=1.
- **Reset mid-operation:** `reset` asserted during DIV_WAIT → outputs at reset values the next cycle and no `rsp_valid`. A fresh req1 afterwards is serviced correctly, and req1 wins because the pointer is 0 and req0 is low.
- **Skip-divide:** with `RSA_MODMUL_SKIP_DIV_EN`, a=3, b=4, n=13 → 12 with `div_rst_n` never low after reset. Without the macro, the same stimulus gives 12 via the divider.

Source files
------------

// File: rtl/rsa_pkg.sv
// Shared types and defaults for the RSA modular-multiply scheduler.
// RSA_NREQ is the default requester count.
package rsa_pkg;

    localparam int RSA_WIDTH = 128;
    localparam int RSA_NREQ  = 2;

    typedef enum logic [2:0] {
        IDLE,
        MUL_GO,
        MUL_WAIT,
        DIV_GO,
        DIV_WAIT,
        RESP
    } modmul_state_t;

endpackage

// File: rtl/rsa_modmul_sched_rr_arbiter.sv
// Round-robin arbiter: picks the first asserted request at or after ptr, wrapping.
// Purely combinational; the caller owns the pointer.
module rr_arbiter #(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] ptr,
    output logic [NREQ-1:0]         winner,
    output logic                    any
);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        winner = '0;
        any    = 1'b0;
        // Upper segment [ptr, NREQ) has priority, then the wrapped segment [0, ptr).
        for (int i = 0; i < NREQ; i++) begin
            if (!any && req[i] && (i >= int'(ptr))) begin
                winner[i] = 1'b1;
                any       = 1'b1;
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!any && req[i]) begin
                winner[i] = 1'b1;
                any       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rsa_modmul_sched.sv
// Shares one sequential multiplier and one divider among NREQ requesters: (a*b) mod n.
// Optional RSA_MODMUL_SKIP_DIV_EN bypasses the divider when the product is already reduced.
module rsa_modmul_sched
    import rsa_pkg::*;
#(
    parameter int WIDTH = RSA_WIDTH,
    parameter int NREQ  = RSA_NREQ
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   op_a,
    input  logic [NREQ*WIDTH-1:0]   op_b,
    input  logic [NREQ*WIDTH-1:0]   op_n,
    output logic [NREQ-1:0]         gnt,
    output logic [NREQ-1:0]         rsp_valid,
    output logic [WIDTH-1:0]        rsp_data,
    output logic                    rsp_err,
    output logic                    mult_rst_n,
    output logic [WIDTH-1:0]        mult_a,
    output logic [WIDTH-1:0]        mult_b,
    input  logic                    mult_done,
    input  logic [2*WIDTH-1:0]      prod,
    output logic                    div_rst_n,
    output logic [2*WIDTH-1:0]      div_a,
    output logic [WIDTH-1:0]        div_b,
    input  logic                    div_done,
    input  logic [WIDTH-1:0]        rem_in
);

    localparam int PW = $clog2(NREQ);

    modmul_state_t      state, state_next;
    logic [PW-1:0]      ptr, owner, win_idx;
    logic [NREQ-1:0]    win;
    logic               win_any;
    logic [WIDTH-1:0]   a_q, b_q, n_q;
    logic [WIDTH-1:0]   sel_a, sel_b, sel_n;
    logic [2*WIDTH-1:0] prod_q;
    logic               skip_hit;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req    (req),
        .ptr    (ptr),
        .winner (win),
        .any    (win_any)
    );

    always_comb begin
        win_idx = '0;
        sel_a   = '0;
        sel_b   = '0;
        sel_n   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win[i]) begin
                win_idx = PW'(i);
                sel_a   = op_a[i*WIDTH +: WIDTH];
                sel_b   = op_b[i*WIDTH +: WIDTH];
                sel_n   = op_n[i*WIDTH +: WIDTH];
            end
        end
    end

`ifdef RSA_MODMUL_SKIP_DIV_EN
    // A product already below n is its own remainder.
    assign skip_hit = (prod[2*WIDTH-1:WIDTH] == '0) && (prod[WIDTH-1:0] < n_q);
`else
    assign skip_hit = 1'b0;
`endif

    // NOTE: synchronous active-high reset; sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        mult_rst_n = !(reset || (state == MUL_GO && n_q != '0));
        div_rst_n  = !(reset || state == DIV_GO);
        rsp_valid  = (state == RESP && !reset) ? gnt : '0;
        unique case (state)
            IDLE:     if (win_any) state_next = MUL_GO;
            MUL_GO:   state_next = (n_q == '0) ? RESP : MUL_WAIT;
            MUL_WAIT: if (mult_done) state_next = skip_hit ? RESP : DIV_GO;
            DIV_GO:   state_next = DIV_WAIT;
            DIV_WAIT: if (div_done) state_next = RESP;
            RESP:     state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr      <= '0;
            owner    <= '0;
            gnt      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            n_q      <= '0;
            prod_q   <= '0;
            rsp_data <= '0;
            rsp_err  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (win_any) begin
                    gnt      <= win;
                    owner    <= win_idx;
                    a_q      <= sel_a;
                    b_q      <= sel_b;
                    n_q      <= sel_n;
                    rsp_data <= '0;
                    rsp_err  <= 1'b0;
                end
                MUL_GO: if (n_q == '0) rsp_err <= 1'b1;
                MUL_WAIT: if (mult_done) begin
                    prod_q <= prod;
                    if (skip_hit) rsp_data <= prod[WIDTH-1:0];
                end
                DIV_WAIT: if (div_done) rsp_data <= rem_in;
                RESP: begin
                    gnt     <= '0;
                    rsp_err <= 1'b0;
                    ptr     <= (owner == PW'(NREQ - 1)) ? '0 : owner + PW'(1);
                end
                default: ;
            endcase
        end
    end

    assign mult_a = a_q;
    assign mult_b = b_q;
    assign div_a  = prod_q;
    assign div_b  = n_q;

endmodule

// File: tb/tb_rsa_modmul_sched.sv
// Scoreboard bench for rsa_modmul_sched with behavioural multiplier/divider engines.
// Expected results are hand-computed; a negedge monitor pops and compares each response.
module tb_rsa_modmul_sched;
    import rsa_pkg::*;

    localparam int W = RSA_WIDTH;
    localparam int N = 2;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [N-1:0]     req = '0;
    logic [N*W-1:0]   op_a = '0, op_b = '0, op_n = '0;
    logic [N-1:0]     gnt, rsp_valid;
    logic [W-1:0]     rsp_data;
    logic             rsp_err;
    logic             mult_rst_n, div_rst_n;
    logic [W-1:0]     mult_a, mult_b, div_b;
    logic [2*W-1:0]   div_a;
    logic             mult_done = 1'b0, div_done = 1'b0;
    logic [2*W-1:0]   prod = '0;
    logic [W-1:0]     rem_in = '0;

    rsa_modmul_sched #(.WIDTH(W), .NREQ(N)) dut (
        .clk(clk), .reset(reset), .req(req),
        .op_a(op_a), .op_b(op_b), .op_n(op_n),
        .gnt(gnt), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .mult_rst_n(mult_rst_n), .mult_a(mult_a), .mult_b(mult_b),
        .mult_done(mult_done), .prod(prod),
        .div_rst_n(div_rst_n), .div_a(div_a), .div_b(div_b),
        .div_done(div_done), .rem_in(rem_in)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    int cyc = 0;
    int m_lat = 2, d_lat = 2, m_cnt = 0, d_cnt = 0;
    int mult_pulses = 0, div_pulses = 0, gnt_cnt = 0, rsp_cnt = 0, grant_cyc = 0;
    logic [N-1:0] prev_gnt = '0;

    typedef struct {
        string        name;
        logic [N-1:0] vld;
        logic [W-1:0] data;
        logic         err;
        int           lat;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Multiplier engine: latency counted from the cycle after its reset pulse.
    always @(posedge clk) begin
        if (!mult_rst_n) begin
            prod      <= {{W{1'b0}}, mult_a} * {{W{1'b0}}, mult_b};
            mult_done <= (m_lat == 0);
            m_cnt     <= 1;
        end else if (!mult_done) begin
            if (m_cnt >= m_lat) mult_done <= 1'b1;
            else                m_cnt     <= m_cnt + 1;
        end
    end

    always @(posedge clk) begin
        if (!div_rst_n) begin
            rem_in   <= (div_b == '0) ? '0 : W'(div_a % {{W{1'b0}}, div_b});
            div_done <= (d_lat == 0);
            d_cnt    <= 1;
        end else if (!div_done) begin
            if (d_cnt >= d_lat) div_done <= 1'b1;
            else                d_cnt    <= d_cnt + 1;
        end
    end

    // Monitor: counts engine pulses, timestamps grants, checks responses against the scoreboard.
    always @(negedge clk) begin
        if (!reset) begin
            if (!mult_rst_n) mult_pulses++;
            if (!div_rst_n)  div_pulses++;
            if (gnt != '0 && prev_gnt == '0) begin
                grant_cyc = cyc;
                gnt_cnt++;
            end
            if (rsp_valid != '0) begin
                rsp_cnt++;
                if (sb.size() == 0) begin
                    timeout_fail("unexpected_rsp");
                end else begin
                    mon_e = sb.pop_front();
                    check($sformatf("%s.rsp_valid", mon_e.name), rsp_valid, mon_e.vld);
                    check($sformatf("%s.rsp_data", mon_e.name), rsp_data, mon_e.data);
                    check($sformatf("%s.rsp_err", mon_e.name), rsp_err, mon_e.err);
                    check($sformatf("%s.latency", mon_e.name), cyc - grant_cyc, mon_e.lat);
                end
            end
        end
        prev_gnt = gnt;
    end

    task automatic set_ops(input int idx, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] n);
        op_a[idx*W +: W] = a;
        op_b[idx*W +: W] = b;
        op_n[idx*W +: W] = n;
    endtask

    task automatic run_op(input string name, input int idx,
                          input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] n,
                          input logic [W-1:0] exp_d, input logic err, input logic skip,
                          input int tm, input int td);
        exp_t e;
        int mp0, dp0, r0, k;
        m_lat = tm;
        d_lat = td;
        set_ops(idx, a, b, n);
        e.name = name;
        e.vld = '0;
        e.vld[idx] = 1'b1;
        e.data = exp_d;
        e.err = err;
        e.lat = err ? 1 : (skip ? 2 + tm : 4 + tm + td);
        sb.push_back(e);
        mp0 = mult_pulses;
        dp0 = div_pulses;
        r0 = rsp_cnt;
        req[idx] = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!gnt[idx] && k < 50);
        req[idx] = 1'b0;
        if (!gnt[idx]) timeout_fail({name, ".grant"});
        k = 0;
        while (rsp_cnt == r0 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        if (rsp_cnt == r0) timeout_fail({name, ".response"});
        @(negedge clk);
        check({name, ".mult_pulse_cycles"}, mult_pulses - mp0, err ? 0 : 1);
        check({name, ".div_pulse_cycles"}, div_pulses - dp0, (err || skip) ? 0 : 1);
    endtask

    // Both requesters held high; grants must alternate starting at requester 0.
    task automatic run_both(input string name, input int n_ops);
        exp_t e;
        int g0, r0, k;
        m_lat = 2;
        d_lat = 3;
        set_ops(0, 128'd5, 128'd5, 128'd7);
        set_ops(1, {1'b1, 127'b0}, 128'd2, {1'b0, {127{1'b1}}});
        for (int i = 0; i < n_ops; i++) begin
            e.name = $sformatf("%s[%0d]", name, i);
            e.vld = (i % 2 == 0) ? 2'b01 : 2'b10;
            e.data = (i % 2 == 0) ? 128'd4 : 128'd2;
            e.err = 1'b0;
            e.lat = 4 + 2 + 3;
            sb.push_back(e);
        end
        g0 = gnt_cnt;
        r0 = rsp_cnt;
        req = 2'b11;
        k = 0;
        while (gnt_cnt < g0 + n_ops && k < n_ops * 100) begin
            @(negedge clk);
            k++;
        end
        req = 2'b00;
        if (gnt_cnt < g0 + n_ops) timeout_fail({name, ".grants"});
        k = 0;
        while (rsp_cnt < r0 + n_ops && k < 500) begin
            @(negedge clk);
            k++;
        end
        if (rsp_cnt < r0 + n_ops) timeout_fail({name, ".responses"});
        @(negedge clk);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int k;
        logic [W-1:0] big_n;
        big_n = 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFF61;

        repeat (3) @(negedge clk);
        check("reset.mult_rst_n", mult_rst_n, 1'b0);
        check("reset.div_rst_n", div_rst_n, 1'b0);
        check("reset.gnt", gnt, 2'b00);
        reset = 1'b0;
        @(negedge clk);
        check("idle.mult_rst_n", mult_rst_n, 1'b1);
        check("idle.div_rst_n", div_rst_n, 1'b1);
        check("idle.rsp_valid", rsp_valid, 2'b00);
        check("idle.rsp_data", rsp_data, 128'd0);
        check("idle.rsp_err", rsp_err, 1'b0);
        check("idle.mult_a", mult_a, 128'd0);
        check("idle.div_a", div_a, 256'd0);

        run_both("alternate", 4);
        run_op("single", 0, 128'd7, 128'd9, 128'd10, 128'd3, 1'b0, 1'b0, 3, 5);
        run_op("div_by_zero", 1, 128'd12, 128'd34, 128'd0, 128'd0, 1'b1, 1'b0, 3, 3);
        run_op("large_zero_lat", 0, big_n - 1, big_n - 1, big_n, 128'd1, 1'b0, 1'b0, 0, 0);
`ifdef RSA_MODMUL_SKIP_DIV_EN
        run_op("skip_div", 1, 128'd3, 128'd4, 128'd13, 128'd12, 1'b0, 1'b1, 2, 4);
`else
        run_op("skip_div", 1, 128'd3, 128'd4, 128'd13, 128'd12, 1'b0, 1'b0, 2, 4);
`endif
        // Leaves the pointer at 1 before the aborted operation.
        run_op("ptr_setup", 0, 128'd7, 128'd9, 128'd10, 128'd3, 1'b0, 1'b0, 1, 1);

        m_lat = 3;
        d_lat = 40;
        set_ops(1, 128'd11, 128'd13, 128'd17);
        req[1] = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!gnt[1] && k < 50);
        req[1] = 1'b0;
        if (!gnt[1]) timeout_fail("abort.grant");
        k = 0;
        while (div_rst_n && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (div_rst_n) timeout_fail("abort.div_go");
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("abort.gnt", gnt, 2'b00);
        check("abort.rsp_valid", rsp_valid, 2'b00);
        check("abort.rsp_data", rsp_data, 128'd0);
        check("abort.rsp_err", rsp_err, 1'b0);
        check("abort.mult_rst_n", mult_rst_n, 1'b0);
        check("abort.div_rst_n", div_rst_n, 1'b0);
        check("abort.mult_a", mult_a, 128'd0);
        check("abort.div_a", div_a, 256'd0);
        check("abort.div_b", div_b, 128'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Pointer must be back at 0, so requester 0 wins first.
        run_both("post_reset", 2);

        repeat (5) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
